crc_word_engine: RTL

CRC_WORD_ENGINE -- requirements
Module: crc_word_engine

---
 rtl/crc_pkg.sv | 15 +
 rtl/crc_xor4.sv | 14 +
 rtl/crc_word_engine.sv | 113 +++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
// Shared definitions for the word-wide CRC engine: FSM states, default
// polynomial-independent constants and the slice lane count.
package crc_pkg;

  localparam logic [31:0] CRC_INIT_DEFAULT   = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_XOROUT_DEFAULT = 32'hFFFFFFFF;
  localparam int unsigned CRC_LANES          = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOK = 2'd1,
    DONE = 2'd2
  } crc_state_e;

endpackage

// File: rtl/crc_xor4.sv
// Four-input XOR reduce used to fold the per-lane slice table outputs.
module crc_xor4 #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  input  logic [W-1:0] d,
  output logic [W-1:0] y
);

  assign y = a ^ b ^ c ^ d;

endmodule

// File: rtl/crc_word_engine.sv
// Word-at-a-time CRC engine using external slicing tables (one per byte lane);
// accepts one 32-bit word every two cycles and reports the CRC per frame.
module crc_word_engine
  import crc_pkg::*;
#(
  parameter logic [31:0] INIT   = CRC_INIT_DEFAULT,
  parameter logic [31:0] XOROUT = CRC_XOROUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic [31:0] tab_addr0,
  output logic [31:0] tab_addr1,
  output logic [31:0] tab_addr2,
  output logic [31:0] tab_addr3,
  input  logic [31:0] tab_rdata0,
  input  logic [31:0] tab_rdata1,
  input  logic [31:0] tab_rdata2,
  input  logic [31:0] tab_rdata3,
  output logic        crc_valid,
  input  logic        crc_ready,
  output logic [31:0] crc_out,
  output logic [15:0] word_cnt
);

  crc_state_e  state_q, state_d;
  logic [31:0] crc_q, crc_d;
  logic [31:0] x_q, x_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic        last_q, last_d;
  logic        rdy_en_q;
  logic [31:0] fold;

  crc_xor4 #(.W(32)) u_fold (
    .a (tab_rdata0),
    .b (tab_rdata1),
    .c (tab_rdata2),
    .d (tab_rdata3),
    .y (fold)
  );

  assign tab_addr0 = {24'h0, x_q[7:0]};
  assign tab_addr1 = {24'h0, x_q[15:8]};
  assign tab_addr2 = {24'h0, x_q[23:16]};
  assign tab_addr3 = {24'h0, x_q[31:24]};

  // in_ready is held low until the first clock edge after reset release.
  assign in_ready  = rdy_en_q && (state_q == IDLE);
  assign crc_valid = (state_q == DONE);
  assign crc_out   = crc_valid ? (crc_q ^ XOROUT) : '0;
  assign word_cnt  = crc_valid ? wcnt_q : '0;

  always_comb begin
    state_d = state_q;
    crc_d   = crc_q;
    x_d     = x_q;
    wcnt_d  = wcnt_q;
    last_d  = last_q;
    if (clr) begin
      state_d = IDLE;
      crc_d   = INIT;
      x_d     = '0;
      wcnt_d  = '0;
      last_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready) begin
            x_d     = crc_q ^ in_data;
            last_d  = in_last;
            wcnt_d  = (wcnt_q == '1) ? wcnt_q : wcnt_q + 16'd1;
            state_d = LOOK;
          end
        end
        LOOK: begin
          crc_d   = fold;
          state_d = last_q ? DONE : IDLE;
        end
        DONE: begin
          if (crc_ready) begin
            crc_d   = INIT;
            wcnt_d  = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      crc_q    <= INIT;
      x_q      <= '0;
      wcnt_q   <= '0;
      last_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      x_q      <= x_d;
      wcnt_q   <= wcnt_d;
      last_q   <= last_d;
      rdy_en_q <= 1'b1;
    end
  end

endmodule
